ysyx_22040759_wbu: RTL and testbench

Write-back unit: the final pipeline stage, sitting directly upstream of the GPR write port. It registers one retiring instruction from MEM using a valid/ready handshake. It formats load data, drives the GPR write port (wen/waddr/wdata) and emits difftest commit info. It counts retired instructions and halts the core on ebreak, reporting the exit code held in a0.

---
 rtl/ysyx_22040759_wbu_pkg.sv | 13 +
 rtl/ysyx_22040759_ld_fmt.sv | 27 ++
 rtl/ysyx_22040759_wbu.sv | 92 +++++++++
 tb/tb_ysyx_22040759_wbu.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040759_wbu_pkg.sv
// ysyx_22040759_wbu_pkg: shared constants and FSM encoding for the write-back unit
package ysyx_22040759_wbu_pkg;
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LD  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;
    localparam logic [2:0] LD_LWU = 3'b110;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
    localparam logic [4:0] A0_IDX = 5'd10;
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} wbu_state_t;
endpackage

// File: rtl/ysyx_22040759_ld_fmt.sv
// ysyx_22040759_ld_fmt: extracts and extends a load field from an aligned 64-bit beat
module ysyx_22040759_ld_fmt (
    input  logic [2:0]  ld_type,
    input  logic [2:0]  addr_lo,
    input  logic [63:0] raw,
    output logic [63:0] data
);
    import ysyx_22040759_wbu_pkg::*;
    logic [2:0]  off;
    logic [63:0] sh;
    always_comb begin
        off = ld_type[1:0] == 2'b00 ? addr_lo :
              ld_type[1:0] == 2'b01 ? {addr_lo[2:1], 1'b0} :
              ld_type[1:0] == 2'b10 ? {addr_lo[2], 2'b00} : 3'b000;
        sh = raw >> {off, 3'b000};
        case (ld_type)
            LD_LB:   data = {{56{sh[7]}}, sh[7:0]};
            LD_LH:   data = {{48{sh[15]}}, sh[15:0]};
            LD_LW:   data = {{32{sh[31]}}, sh[31:0]};
            LD_LD:   data = sh;
            LD_LBU:  data = {56'd0, sh[7:0]};
            LD_LHU:  data = {48'd0, sh[15:0]};
            LD_LWU:  data = {32'd0, sh[31:0]};
            default: data = '0;
        endcase
    end
endmodule

// File: rtl/ysyx_22040759_wbu.sv
// ysyx_22040759_wbu: write-back stage driving the GPR write port, commit info and ebreak halt
module ysyx_22040759_wbu #(
    parameter int          XLEN        = 64,
    parameter logic [31:0] EBREAK_INST = ysyx_22040759_wbu_pkg::EBREAK_INST,
    parameter logic [4:0]  A0_IDX      = ysyx_22040759_wbu_pkg::A0_IDX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [XLEN-1:0] mem_pc,
    input  logic [31:0]     mem_inst,
    input  logic [4:0]      mem_rd,
    input  logic            mem_rd_wen,
    input  logic            mem_wb_sel,
    input  logic [XLEN-1:0] mem_alu_res,
    input  logic [63:0]     mem_ld_data,
    input  logic [2:0]      mem_ld_type,
    input  logic [2:0]      mem_addr_lo,
    output logic            gpr_wen,
    output logic [4:0]      gpr_waddr,
    output logic [XLEN-1:0] gpr_wdata,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [31:0]     commit_inst,
    output logic [63:0]     instret,
    output logic            halt,
    output logic [XLEN-1:0] halt_code
);
    import ysyx_22040759_wbu_pkg::*;
    wbu_state_t      state, state_nxt;
    logic            accept;
    logic            wb_valid;
    logic [XLEN-1:0] wb_pc;
    logic [31:0]     wb_inst;
    logic [4:0]      wb_rd;
    logic            wb_rd_wen;
    logic [XLEN-1:0] wb_res;
    logic [XLEN-1:0] a0_shadow;
    logic [63:0]     ld_val;

    ysyx_22040759_ld_fmt u_ld_fmt (
        .ld_type (mem_ld_type),
        .addr_lo (mem_addr_lo),
        .raw     (mem_ld_data),
        .data    (ld_val)
    );

    always_comb begin
        mem_ready    = state == RUN;
        accept       = mem_valid & mem_ready;
        state_nxt    = (accept && mem_inst == EBREAK_INST) ? HALT : state;
        gpr_wen      = wb_valid & wb_rd_wen & (wb_rd != 5'd0);
        gpr_waddr    = wb_rd;
        gpr_wdata    = wb_res;
        commit_valid = wb_valid;
        commit_pc    = wb_pc;
        commit_inst  = wb_inst;
        halt         = state == HALT;
        halt_code    = halt ? a0_shadow : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Formatted load data is captured so the GPR port stays a plain register read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_pc     <= '0;
            wb_inst   <= '0;
            wb_rd     <= '0;
            wb_rd_wen <= 1'b0;
            wb_res    <= '0;
            instret   <= '0;
            a0_shadow <= '0;
        end else begin
            wb_valid <= accept;
            if (accept) begin
                wb_pc     <= mem_pc;
                wb_inst   <= mem_inst;
                wb_rd     <= mem_rd;
                wb_rd_wen <= mem_rd_wen;
                wb_res    <= mem_wb_sel ? ld_val[XLEN-1:0] : mem_alu_res;
            end
            if (commit_valid) instret <= instret + 64'd1;
            if (gpr_wen && gpr_waddr == A0_IDX) a0_shadow <= gpr_wdata;
        end
    end
endmodule

// File: tb/tb_ysyx_22040759_wbu.sv
// tb_ysyx_22040759_wbu: directed stimulus with a cycle-level reference model and literal pins
module tb_ysyx_22040759_wbu;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [63:0] LDV    = 64'h8877_6655_4433_2211;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [63:0] mem_pc = '0;
    logic [31:0] mem_inst = '0;
    logic [4:0]  mem_rd = '0;
    logic        mem_rd_wen = 1'b0;
    logic        mem_wb_sel = 1'b0;
    logic [63:0] mem_alu_res = '0;
    logic [63:0] mem_ld_data = '0;
    logic [2:0]  mem_ld_type = '0;
    logic [2:0]  mem_addr_lo = '0;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [63:0] gpr_wdata;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [31:0] commit_inst;
    logic [63:0] instret;
    logic        halt;
    logic [63:0] halt_code;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    ysyx_22040759_wbu dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_rd(mem_rd), .mem_rd_wen(mem_rd_wen),
        .mem_wb_sel(mem_wb_sel), .mem_alu_res(mem_alu_res), .mem_ld_data(mem_ld_data),
        .mem_ld_type(mem_ld_type), .mem_addr_lo(mem_addr_lo),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .instret(instret), .halt(halt), .halt_code(halt_code)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load formatter: size-based arithmetic on byte fields
    function automatic logic [63:0] fmt(input logic [63:0] d, input logic [2:0] t, input logic [2:0] lo);
        int sz, off;
        logic [63:0] mask, v;
        sz = 1 << t[1:0];
        off = (int'(lo) / sz) * sz;
        mask = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
        v = (d >> (8 * off)) & mask;
        if (!t[2] && sz < 8 && v[8 * sz - 1]) v = v | ~mask;
        return (t == 3'b111) ? 64'd0 : v;
    endfunction

    // Model: what sits in write-back, how many retired, what a0 holds, whether halted
    logic        m_valid, m_wen, m_halt;
    logic [4:0]  m_rd;
    logic [63:0] m_pc, m_res, m_instret, m_a0;
    logic [31:0] m_inst;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 0; m_wen <= 0; m_halt <= 0; m_rd <= 0;
            m_pc <= 0; m_res <= 0; m_instret <= 0; m_a0 <= 0; m_inst <= 0;
        end else begin
            if (m_valid) m_instret <= m_instret + 1;
            if (m_valid && m_wen && m_rd == 5'd10) m_a0 <= m_res;
            m_valid <= mem_valid && !m_halt;
            if (mem_valid && !m_halt) begin
                m_pc <= mem_pc; m_inst <= mem_inst; m_rd <= mem_rd; m_wen <= mem_rd_wen;
                m_res <= mem_wb_sel ? fmt(mem_ld_data, mem_ld_type, mem_addr_lo) : mem_alu_res;
                if (mem_inst == EBREAK) m_halt <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("m_ready", {63'd0, mem_ready}, {63'd0, !m_halt});
            chk("m_commit", {63'd0, commit_valid}, {63'd0, m_valid});
            chk("m_wen", {63'd0, gpr_wen}, {63'd0, m_valid && m_wen && m_rd != 0});
            if (m_valid) begin
                chk("m_pc", commit_pc, m_pc);
                chk("m_inst", {32'd0, commit_inst}, {32'd0, m_inst});
            end
            if (m_valid && m_wen && m_rd != 0) begin
                chk("m_waddr", {59'd0, gpr_waddr}, {59'd0, m_rd});
                chk("m_wdata", gpr_wdata, m_res);
            end
            chk("m_instret", instret, m_instret);
            chk("m_halt", {63'd0, halt}, {63'd0, m_halt});
            chk("m_hcode", halt_code, m_halt ? m_a0 : 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [63:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                         input logic wen, input logic sel, input logic [63:0] alu,
                         input logic [2:0] typ, input logic [2:0] lo);
        mem_valid = 1; mem_pc = pc; mem_inst = inst; mem_rd = rd; mem_rd_wen = wen;
        mem_wb_sel = sel; mem_alu_res = alu; mem_ld_data = LDV; mem_ld_type = typ; mem_addr_lo = lo;
    endtask

    task automatic idle();
        mem_valid = 0;
    endtask

    task automatic ld_case(input string name, input logic [2:0] typ, input logic [2:0] lo, input logic [63:0] exp);
        drive(64'h8000_0100, 32'h0000_3083, 5'd1, 1, 1, 64'hDEAD, typ, lo);
        step();
        idle();
        chk(name, gpr_wdata, exp);
        step();
    endtask

    initial begin
        int cnt;
        #3;
        chk("rst_ready", {63'd0, mem_ready}, 64'd1);
        chk("rst_commit", {63'd0, commit_valid}, 64'd0);
        chk("rst_wen", {63'd0, gpr_wen}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_halt", {63'd0, halt}, 64'd0);
        step();
        rst = 0;
        chk_en = 1;
        drive(64'h8000_0000, 32'h0000_0013, 5'd5, 1, 0, 64'h1234, 3'd0, 3'd0);
        step();
        idle();
        chk("alu_wen", {63'd0, gpr_wen}, 64'd1);
        chk("alu_waddr", {59'd0, gpr_waddr}, 64'd5);
        chk("alu_wdata", gpr_wdata, 64'h1234);
        chk("alu_commit", {63'd0, commit_valid}, 64'd1);
        step();
        chk("alu_instret", instret, 64'd1);
        ld_case("lb7", 3'b000, 3'd7, 64'hFFFF_FFFF_FFFF_FF88);
        ld_case("lbu7", 3'b100, 3'd7, 64'h88);
        ld_case("lh3", 3'b001, 3'd3, 64'h4433);
        ld_case("lw4", 3'b010, 3'd4, 64'hFFFF_FFFF_8877_6655);
        ld_case("lwu4", 3'b110, 3'd4, 64'h8877_6655);
        ld_case("ld", 3'b011, 3'd0, LDV);
        ld_case("t111", 3'b111, 3'd5, 64'd0);
        drive(64'h8000_0200, 32'h0010_0013, 5'd0, 1, 0, 64'h77, 3'd0, 3'd0);
        step();
        idle();
        chk("x0_wen", {63'd0, gpr_wen}, 64'd0);
        chk("x0_commit", {63'd0, commit_valid}, 64'd1);
        step();
        chk("x0_instret", instret, 64'd9);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(64'h8000_1000 + 64'(4 * i), 32'h0000_0013, 5'(i + 1), 1, 0, 64'(i * 3), 3'd0, 3'd0);
            step();
            if (commit_valid) cnt++;
        end
        idle();
        chk("b2b_commits", 64'(cnt), 64'd10);
        step();
        chk("b2b_instret", instret, 64'd19);
        chk("b2b_idle", {63'd0, commit_valid}, 64'd0);
        drive(64'h8000_2000, 32'h02A0_0513, 5'd10, 1, 0, 64'h2A, 3'd0, 3'd0);
        step();
        drive(64'h8000_2004, EBREAK, 5'd0, 0, 0, 64'd0, 3'd0, 3'd0);
        step();
        chk("eb_commit", {63'd0, commit_valid}, 64'd1);
        chk("eb_inst", {32'd0, commit_inst}, {32'd0, EBREAK});
        chk("eb_halt", {63'd0, halt}, 64'd1);
        chk("eb_code", halt_code, 64'h2A);
        chk("eb_ready", {63'd0, mem_ready}, 64'd0);
        drive(64'h8000_2008, 32'h0000_0013, 5'd3, 1, 0, 64'h99, 3'd0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_nocommit", {63'd0, commit_valid}, 64'd0);
        end
        idle();
        chk("halt_instret", instret, 64'd21);
        chk("halt_code_hold", halt_code, 64'h2A);
        rst = 1;
        #1;
        chk("rst2_halt", {63'd0, halt}, 64'd0);
        step();
        rst = 0;
        drive(64'h8000_3000, 32'h0000_0013, 5'd4, 1, 0, 64'h44, 3'd0, 3'd0);
        step();
        idle();
        chk("pre_rst_commit", {63'd0, commit_valid}, 64'd1);
        rst = 1;
        #1;
        chk("arst_commit", {63'd0, commit_valid}, 64'd0);
        chk("arst_wen", {63'd0, gpr_wen}, 64'd0);
        chk("arst_instret", instret, 64'd0);
        chk("arst_halt", {63'd0, halt}, 64'd0);
        chk("arst_ready", {63'd0, mem_ready}, 64'd1);
        rst = 0;
        drive(64'h8000_4000, 32'h0000_0013, 5'd3, 1, 0, 64'h55, 3'd0, 3'd0);
        step();
        idle();
        chk("resume_wdata", gpr_wdata, 64'h55);
        chk("resume_commit", {63'd0, commit_valid}, 64'd1);
        step();
        chk("resume_instret", instret, 64'd1);
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
